// File: rtl/jogo_defs_pkg.sv
//==============================================================================
// Module      : jogo_defs (package)
// Description : Shared definitions for the play control path: the 4-bit state
//               codes shown on the debug display, the state enumeration, the
//               default wait timeout, and the Moore output decode used by the
//               control unit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package jogo_defs;

    // Default number of cycles a player has to make a move.
    localparam int TIMEOUT_CYCLES_PADRAO = 5000;

    // State codes; the 7-segment debug decoder relies on these exact values.
    localparam logic [3:0] c_inicial       = 4'd0;
    localparam logic [3:0] c_preparacao    = 4'd1;
    localparam logic [3:0] c_espera_jogada = 4'd2;
    localparam logic [3:0] c_registra      = 4'd3;
    localparam logic [3:0] c_comparacao    = 4'd4;
    localparam logic [3:0] c_proximo       = 4'd5;
    localparam logic [3:0] c_fim_acertou   = 4'd6;
    localparam logic [3:0] c_fim_errou     = 4'd7;
    localparam logic [3:0] c_fim_timeout   = 4'd8;

    typedef enum logic [3:0] {
        ESTADO_INICIAL       = c_inicial,
        ESTADO_PREPARACAO    = c_preparacao,
        ESTADO_ESPERA_JOGADA = c_espera_jogada,
        ESTADO_REGISTRA      = c_registra,
        ESTADO_COMPARACAO    = c_comparacao,
        ESTADO_PROXIMO       = c_proximo,
        ESTADO_FIM_ACERTOU   = c_fim_acertou,
        ESTADO_FIM_ERROU     = c_fim_errou,
        ESTADO_FIM_TIMEOUT   = c_fim_timeout
    } estado_t;

    typedef struct packed {
        logic zera_regs;
        logic registra;
        logic zera_contador;
        logic conta_endereco;
        logic pronto;
        logic acertou;
        logic errou;
        logic timeout;
    } saidas_t;

    // Moore output table: every control output is a function of the state only.
    function automatic saidas_t decodifica_saidas(input estado_t estado);
        saidas_t s;
        s = '0;
        case (estado)
            ESTADO_PREPARACAO: begin
                s.zera_regs     = 1'b1;
                s.zera_contador = 1'b1;
            end
            ESTADO_REGISTRA:    s.registra       = 1'b1;
            ESTADO_PROXIMO:     s.conta_endereco = 1'b1;
            ESTADO_FIM_ACERTOU: begin
                s.pronto  = 1'b1;
                s.acertou = 1'b1;
            end
            ESTADO_FIM_ERROU: begin
                s.pronto = 1'b1;
                s.errou  = 1'b1;
            end
            ESTADO_FIM_TIMEOUT: begin
                s.pronto  = 1'b1;
                s.timeout = 1'b1;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/unidade_controle_jogada_contador_timeout.sv
//==============================================================================
// Module      : contador_timeout
// Description : Wait-state timer. Counts enabled cycles from zero and flags
//               fim when the count reaches TIMEOUT_CYCLES-1.
// Ports       : clock  - system clock, rising edge
//               reset  - synchronous active-high reset
//               clear  - synchronous clear (priority over enable)
//               enable - count enable
//               fim    - count equals TIMEOUT_CYCLES-1
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module contador_timeout #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic fim
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] c_limite = W'(TIMEOUT_CYCLES - 1);
    localparam logic [W-1:0] c_um     = W'(1);

    logic [W-1:0] r_contagem;

    // The owner leaves the enabled state on fim, so the count never wraps.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_contagem <= '0;
        end else if (enable) begin
            r_contagem <= r_contagem + c_um;
        end
    end

    assign fim = (r_contagem == c_limite);

endmodule

`default_nettype wire

// File: rtl/unidade_controle_jogada.sv
//==============================================================================
// Module      : unidade_controle_jogada
// Description : Moore FSM sequencing the play datapath: clears the play
//               registers and address counter, waits for a move (with
//               timeout), captures it, checks the comparator and either
//               advances the address or ends the round.
// Ports       : clock, reset          - clock / synchronous active-high reset
//               iniciar              - start/restart request
//               jogada               - one-cycle move pulse
//               igual, fim_sequencia - comparator / last-address status
//               zera_regs, registra  - play register clear / enable
//               zera_contador        - address counter clear
//               conta_endereco       - address counter count enable
//               pronto, acertou, errou, timeout - round result flags
//               db_estado            - current state code for debug
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module unidade_controle_jogada
    import jogo_defs::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fim_sequencia,
    output logic       zera_regs,
    output logic       registra,
    output logic       zera_contador,
    output logic       conta_endereco,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    estado_t r_estado;
    estado_t w_proximo;
    saidas_t r_saidas;
    logic    w_em_espera;
    logic    w_expirou;

    assign w_em_espera = (r_estado == ESTADO_ESPERA_JOGADA);

    // Timer runs only while waiting and restarts from zero on every entry.
    contador_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_contador_timeout (
        .clock (clock),
        .reset (reset),
        .clear (!w_em_espera),
        .enable(w_em_espera),
        .fim   (w_expirou)
    );

    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            ESTADO_INICIAL:       w_proximo = iniciar ? ESTADO_PREPARACAO : ESTADO_INICIAL;
            ESTADO_PREPARACAO:    w_proximo = ESTADO_ESPERA_JOGADA;
            ESTADO_ESPERA_JOGADA: begin
                // A move arriving on the last allowed cycle still counts.
                if (jogada)         w_proximo = ESTADO_REGISTRA;
                else if (w_expirou) w_proximo = ESTADO_FIM_TIMEOUT;
                else                w_proximo = ESTADO_ESPERA_JOGADA;
            end
            ESTADO_REGISTRA:      w_proximo = ESTADO_COMPARACAO;
            ESTADO_COMPARACAO: begin
                // A wrong move ends the round even on the last position.
                if (!igual)             w_proximo = ESTADO_FIM_ERROU;
                else if (fim_sequencia) w_proximo = ESTADO_FIM_ACERTOU;
                else                    w_proximo = ESTADO_PROXIMO;
            end
            ESTADO_PROXIMO:       w_proximo = ESTADO_ESPERA_JOGADA;
            ESTADO_FIM_ACERTOU,
            ESTADO_FIM_ERROU,
            ESTADO_FIM_TIMEOUT:   w_proximo = iniciar ? ESTADO_PREPARACAO : r_estado;
            default:              w_proximo = ESTADO_INICIAL;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so they always equal the decode of the current state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= ESTADO_INICIAL;
            r_saidas <= '0;
        end else begin
            r_estado <= w_proximo;
            r_saidas <= decodifica_saidas(w_proximo);
        end
    end

    assign zera_regs      = r_saidas.zera_regs;
    assign registra       = r_saidas.registra;
    assign zera_contador  = r_saidas.zera_contador;
    assign conta_endereco = r_saidas.conta_endereco;
    assign pronto         = r_saidas.pronto;
    assign acertou        = r_saidas.acertou;
    assign errou          = r_saidas.errou;
    assign timeout        = r_saidas.timeout;
    assign db_estado      = r_estado;

endmodule

`default_nettype wire
